// File: rtl/enc_link_scheduler.sv
// Link-layer sequencer for an 8b/10b encoder: comma sync, round-robin sharing of
// the encoder between two byte requesters, periodic commas and error-driven resync.
module enc_link_scheduler #(
    parameter int SYNC_LEN     = 4,
    parameter int COMMA_PERIOD = 8,
    parameter int ERR_LIMIT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_k,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_k,
    output logic       req1_ready,
    input  logic       dec_invalid,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       enc_enb,
    output logic       link_up,
    output logic [1:0] state
);

    localparam int SYNC_W  = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int COMMA_W = $clog2(COMMA_PERIOD);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

    localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(SYNC_LEN - 1);
    localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(COMMA_PERIOD - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = ERR_W'(ERR_LIMIT);
    localparam logic [7:0]         K28_5      = 8'hBC;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_SYNC = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [SYNC_W-1:0]  sync_cnt_reg, sync_cnt_next;
    logic [COMMA_W-1:0] comma_cnt_reg, comma_cnt_next;
    logic [ERR_W-1:0]   err_cnt_reg, err_cnt_next;
    logic               ptr_reg, ptr_next;
    logic [7:0]         enc_data_reg, enc_data_next;
    logic               enc_k_reg, enc_k_next;
    logic               enc_enb_reg, enc_enb_next;
    logic               link_up_reg, link_up_next;

    logic [1:0] valid_vec;
    logic [7:0] data_vec [2];
    logic [1:0] k_vec;
    logic [1:0] grant;
    logic       slot_open;
    logic       sel_idx;
    logic [7:0] sel_data;
    logic       sel_k;
    logic       go_sync;

    // Requester ports folded into indexable vectors so arbitration is index-based.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        if (gi == 0) begin : g_r0
            assign valid_vec[gi] = req0_valid;
            assign data_vec[gi]  = req0_data;
            assign k_vec[gi]     = req0_k;
        end else begin : g_r1
            assign valid_vec[gi] = req1_valid;
            assign data_vec[gi]  = req1_data;
            assign k_vec[gi]     = req1_k;
        end
    end

    // A data slot exists only in a healthy, enabled RUN cycle that is not a comma slot.
    assign slot_open = (state_reg == ST_RUN) && link_en &&
                       (err_cnt_reg != ERR_MAX) && (comma_cnt_reg != COMMA_LAST);

    // ptr_reg = 1 means requester 1 wins the next tie.
    always_comb begin
        grant = 2'b00;
        if (slot_open) begin
            case (valid_vec)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel_idx    = grant[1];
    assign sel_data   = data_vec[sel_idx];
    assign sel_k      = k_vec[sel_idx];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_next     = state_reg;
        sync_cnt_next  = sync_cnt_reg;
        comma_cnt_next = comma_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        ptr_next       = ptr_reg;
        enc_data_next  = 8'h00;
        enc_k_next     = 1'b0;
        enc_enb_next   = 1'b0;
        link_up_next   = 1'b0;
        go_sync        = 1'b0;

        case (state_reg)
            ST_OFF: begin
                sync_cnt_next  = '0;
                comma_cnt_next = '0;
                err_cnt_next   = '0;
                if (link_en) begin
                    go_sync = 1'b1;
                end
            end

            ST_SYNC: begin
                if (!link_en) begin
                    state_next = ST_OFF;
                end else if (sync_cnt_reg == SYNC_LAST) begin
                    // First RUN character is an idle comma; no byte could be accepted yet.
                    state_next    = ST_RUN;
                    enc_data_next = K28_5;
                    enc_k_next    = 1'b1;
                    enc_enb_next  = 1'b1;
                    link_up_next  = 1'b1;
                end else begin
                    sync_cnt_next = sync_cnt_reg + SYNC_W'(1);
                    enc_data_next = K28_5;
                    enc_k_next    = 1'b1;
                    enc_enb_next  = 1'b1;
                end
            end

            ST_RUN: begin
                if (!link_en) begin
                    state_next = ST_OFF;
                end else if (err_cnt_reg == ERR_MAX) begin
                    go_sync = 1'b1;
                end else begin
                    link_up_next = 1'b1;
                    enc_enb_next = 1'b1;
                    err_cnt_next = dec_invalid ? (err_cnt_reg + ERR_W'(1)) : '0;
                    if (comma_cnt_reg == COMMA_LAST) begin
                        comma_cnt_next = '0;
                        enc_data_next  = K28_5;
                        enc_k_next     = 1'b1;
                    end else begin
                        comma_cnt_next = comma_cnt_reg + COMMA_W'(1);
                        if (grant != 2'b00) begin
                            enc_data_next = sel_data;
                            enc_k_next    = sel_k;
                            ptr_next      = grant[0];
                        end else begin
                            enc_data_next = K28_5;
                            enc_k_next    = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_OFF;
            end
        endcase

        if (go_sync) begin
            state_next     = ST_SYNC;
            sync_cnt_next  = '0;
            comma_cnt_next = '0;
            err_cnt_next   = '0;
            enc_data_next  = K28_5;
            enc_k_next     = 1'b1;
            enc_enb_next   = 1'b1;
            link_up_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_OFF;
            sync_cnt_reg  <= '0;
            comma_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            ptr_reg       <= 1'b0;
            enc_data_reg  <= 8'h00;
            enc_k_reg     <= 1'b0;
            enc_enb_reg   <= 1'b0;
            link_up_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sync_cnt_reg  <= sync_cnt_next;
            comma_cnt_reg <= comma_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            ptr_reg       <= ptr_next;
            enc_data_reg  <= enc_data_next;
            enc_k_reg     <= enc_k_next;
            enc_enb_reg   <= enc_enb_next;
            link_up_reg   <= link_up_next;
        end
    end

    assign enc_data = enc_data_reg;
    assign enc_k    = enc_k_reg;
    assign enc_enb  = enc_enb_reg;
    assign link_up  = link_up_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_enc_link_scheduler.sv
// Directed scoreboard bench for enc_link_scheduler: each vector pushes its expected
// per-cycle response; a negedge monitor pops and compares.
module tb_enc_link_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en;
    logic       req0_valid, req0_k, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_k, req1_ready;
    logic [7:0] req1_data;
    logic       dec_invalid;
    logic [7:0] enc_data;
    logic       enc_k, enc_enb, link_up;
    logic [1:0] state;

    localparam logic [1:0] OFF = 2'b00, SY = 2'b01, RU = 2'b10;

    typedef struct packed {
        logic [1:0] st;
        logic       r0;
        logic       r1;
        logic       k;
        logic [7:0] d;
        logic       enb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vec_cnt = 0;
    int   miscompares = 0;

    enc_link_scheduler dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_k(req0_k), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_k(req1_k), .req1_ready(req1_ready),
        .dec_invalid(dec_invalid),
        .enc_data(enc_data), .enc_k(enc_k), .enc_enb(enc_enb), .link_up(link_up), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input int act, input int req);
        if (act != req) begin
            $display("FAIL vec %0d %s: got %0h, expected %0h", idx, name, act, req);
            miscompares++;
        end
    endtask

    // One clock cycle of stimulus plus the outputs expected to be visible in that cycle.
    task automatic vec(input logic en, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic kk, input logic dec,
                       input logic [1:0] st, input logic r0, input logic r1,
                       input logic k, input logic [7:0] d, input logic enb);
        exp_t e;
        @(posedge clk);
        #1;
        link_en     = en;
        req0_valid  = v0;
        req0_data   = d0;
        req0_k      = kk;
        req1_valid  = v1;
        req1_data   = d1;
        req1_k      = kk;
        dec_invalid = dec;
        e.st = st; e.r0 = r0; e.r1 = r1; e.k = k; e.d = d; e.enb = enb;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            vec_cnt++;
            chk(vec_cnt, "state", int'(state), int'(mon_e.st));
            chk(vec_cnt, "link_up", int'(link_up), int'(mon_e.st == RU));
            chk(vec_cnt, "req0_ready", int'(req0_ready), int'(mon_e.r0));
            chk(vec_cnt, "req1_ready", int'(req1_ready), int'(mon_e.r1));
            chk(vec_cnt, "enc_enb", int'(enc_enb), int'(mon_e.enb));
            chk(vec_cnt, "enc_k", int'(enc_k), int'(mon_e.k));
            chk(vec_cnt, "enc_data", int'(enc_data), int'(mon_e.d));
            $display("vec %0d: state=%0d rdy=%0b%0b enb=%0b k=%0b data=%02h", vec_cnt,
                     state, req1_ready, req0_ready, enc_enb, enc_k, enc_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst = 1'b0; link_en = 1'b0; dec_invalid = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_k = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_k = 1'b0;

        // Reset and bring-up
        vec(0, 0,8'h00, 0,8'h00, 0,0, OFF,0,0, 0,8'h00,0);
        vec(0, 0,8'h00, 0,8'h00, 0,0, OFF,0,0, 0,8'h00,0);
        rst = 1'b1;
        vec(1, 0,8'h00, 0,8'h00, 0,0, OFF,0,0, 0,8'h00,0);
        for (int i = 0; i < 4; i++) vec(1, 0,8'h00, 0,8'h00, 0,0, SY,0,0, 1,8'hBC,1);

        // Arbitration: both valid, comma slot at RUN cycle 7
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,1,0, 1,8'hBC,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,0,1, 0,8'h11,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,1,0, 0,8'h22,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,0,1, 0,8'h11,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,1,0, 0,8'h22,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,0,1, 0,8'h11,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,1,0, 0,8'h22,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,0,0, 0,8'h11,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,0,1, 1,8'hBC,1);
        vec(1, 1,8'h11, 1,8'h22, 0,0, RU,1,0, 0,8'h22,1);

        // Idle
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 0,8'h11,1);
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 1,8'hBC,1);

        // Single requester stream; last byte is a K char blocked by a comma slot
        vec(1, 1,8'h00, 0,8'h00, 0,0, RU,1,0, 1,8'hBC,1);
        vec(1, 1,8'h01, 0,8'h00, 0,0, RU,1,0, 0,8'h00,1);
        vec(1, 1,8'h02, 0,8'h00, 0,0, RU,1,0, 0,8'h01,1);
        vec(1, 1,8'h7C, 0,8'h00, 1,0, RU,0,0, 0,8'h02,1);
        vec(1, 1,8'h7C, 0,8'h00, 1,0, RU,1,0, 1,8'hBC,1);

        // Two errors then clear: stays in RUN; then three in a row: resync
        vec(1, 0,8'h00, 0,8'h00, 0,1, RU,0,0, 1,8'h7C,1);
        vec(1, 0,8'h00, 0,8'h00, 0,1, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 0,8'h00, 0,1, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 0,8'h00, 0,1, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 0,8'h00, 0,1, RU,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 1,8'h33, 0,0, RU,0,0, 1,8'hBC,1);
        for (int i = 0; i < 4; i++) vec(1, 0,8'h00, 1,8'h33, 0,1, SY,0,0, 1,8'hBC,1);
        vec(1, 0,8'h00, 1,8'h33, 0,0, RU,0,1, 1,8'hBC,1);

        // Disable while req1 is valid
        vec(0, 0,8'h00, 1,8'h44, 0,0, RU,0,0, 0,8'h33,1);
        vec(0, 0,8'h00, 1,8'h44, 0,0, OFF,0,0, 0,8'h00,0);
        vec(1, 0,8'h00, 0,8'h00, 0,0, OFF,0,0, 0,8'h00,0);
        vec(1, 0,8'h00, 0,8'h00, 0,0, SY,0,0, 1,8'hBC,1);

        // Asynchronous reset mid-SYNC: outputs clear without a clock edge
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        vec_cnt++;
        chk(vec_cnt, "async_state", int'(state), 0);
        chk(vec_cnt, "async_enb", int'(enc_enb), 0);
        chk(vec_cnt, "async_k", int'(enc_k), 0);
        chk(vec_cnt, "async_data", int'(enc_data), 0);
        chk(vec_cnt, "async_link_up", int'(link_up), 0);
        $display("vec %0d: async reset state=%0d enb=%0b k=%0b data=%02h", vec_cnt,
                 state, enc_enb, enc_k, enc_data);
        vec(1, 0,8'h00, 0,8'h00, 0,0, OFF,0,0, 0,8'h00,0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) vec(1, 0,8'h00, 0,8'h00, 0,0, SY,0,0, 1,8'hBC,1);
        vec(1, 1,8'h55, 1,8'h66, 0,0, RU,1,0, 1,8'hBC,1);
        vec(1, 1,8'h55, 1,8'h66, 0,0, RU,0,1, 0,8'h55,1);
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 0,8'h66,1);
        vec(1, 0,8'h00, 0,8'h00, 0,0, RU,0,0, 1,8'hBC,1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
